// File: rtl/oneshot_scoreboard_if.sv
// Label / inference handshake bundle for the one-shot accuracy scoreboard.
// The master drives labels and predictions; the scoreboard answers with label_ready.
interface oneshot_scoreboard_if;
  logic       label_valid;
  logic [4:0] label_class;
  logic       label_ready;
  logic       checking_inference;
  logic [4:0] class_inference;

  modport master (
    output label_valid,
    output label_class,
    output checking_inference,
    output class_inference,
    input  label_ready
  );

  modport slave (
    input  label_valid,
    input  label_class,
    input  checking_inference,
    input  class_inference,
    output label_ready
  );
endinterface

// File: rtl/oneshot_scoreboard.sv
// Accuracy scoreboard for one-shot classification test runs: queues true labels,
// compares each against the predicted class and keeps saturating global/per-class tallies.
module oneshot_scoreboard #(
  parameter int unsigned NUM_CLASSES = 26,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned LBL_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 en,
  input  logic                 start_scoring,
  oneshot_scoreboard_if.slave  sb_if,
  input  logic                 testing_dataset_finished,
  input  logic [4:0]           class_rd_sel,
  output logic [CNT_W-1:0]     class_rd_total,
  output logic [CNT_W-1:0]     class_rd_correct,
  output logic [CNT_W-1:0]     total_count,
  output logic [CNT_W-1:0]     correct_count,
  output logic [2:0]           err_flags,
  output logic                 scoring_active,
  output logic                 scoring_done
);

  localparam int unsigned CLS_W  = 5;
  localparam int unsigned PTR_W  = (LBL_DEPTH > 1) ? $clog2(LBL_DEPTH) : 1;
  localparam int unsigned FCNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t state, state_next;

  // Label FIFO
  logic [CLS_W-1:0]  fifo_mem [LBL_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [FCNT_W-1:0] fifo_count, fifo_count_after, fifo_count_next;
  logic [CLS_W-1:0]  head;

  // Per-class tallies
  logic [CNT_W-1:0]  cls_total   [NUM_CLASSES];
  logic [CNT_W-1:0]  cls_correct [NUM_CLASSES];
  logic [CNT_W-1:0]  rd_total_c, rd_correct_c;

  logic label_ready_q;

  // Datapath controls from the output decode
  logic clear, act_ev, push_req, push_ok, range_err;
  logic infer, pop_ok, miss, hit, finish, extra;
  logic ready_next, active_next, done_next;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  assign head              = fifo_mem[rd_ptr];
  assign sb_if.label_ready = label_ready_q;

  // State register
  always_ff @(posedge clk) begin
    if (!nrst) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state decode; start_scoring wins from any state
  always_comb begin
    state_next = state;
    if (en) begin
      if (start_scoring) begin
        state_next = S_ACTIVE;
      end else begin
        case (state)
          S_ACTIVE: if (testing_dataset_finished) state_next = S_DONE;
          S_IDLE:   state_next = S_IDLE;
          S_DONE:   state_next = S_DONE;
          default:  state_next = S_IDLE;
        endcase
      end
    end
  end

  // Output / control decode
  always_comb begin
    clear            = 1'b0;
    act_ev           = 1'b0;
    push_req         = 1'b0;
    push_ok          = 1'b0;
    range_err        = 1'b0;
    infer            = 1'b0;
    pop_ok           = 1'b0;
    miss             = 1'b0;
    hit              = 1'b0;
    finish           = 1'b0;
    extra            = 1'b0;
    fifo_count_after = fifo_count;
    fifo_count_next  = fifo_count;
    ready_next       = 1'b0;
    active_next      = 1'b0;
    done_next        = 1'b0;

    clear  = en & start_scoring;
    act_ev = en & ~start_scoring & (state == S_ACTIVE);

    push_req  = act_ev & sb_if.label_valid & label_ready_q;
    push_ok   = push_req & (32'(sb_if.label_class) < NUM_CLASSES);
    range_err = push_req & ~push_ok;

    // No bypass: an inference on an empty FIFO misses even if a label arrives now
    infer  = act_ev & sb_if.checking_inference;
    pop_ok = infer & (fifo_count != '0);
    miss   = infer & (fifo_count == '0);
    hit    = pop_ok & (head == sb_if.class_inference);

    fifo_count_after = fifo_count + FCNT_W'(push_ok) - FCNT_W'(pop_ok);
    finish           = act_ev & testing_dataset_finished;
    extra            = finish & (fifo_count_after != '0);

    if (!en)                 fifo_count_next = fifo_count;
    else if (clear | finish) fifo_count_next = '0;
    else                     fifo_count_next = fifo_count_after;

    ready_next  = (state_next == S_ACTIVE) && (fifo_count_next < FCNT_W'(LBL_DEPTH));
    active_next = (state_next == S_ACTIVE);
    done_next   = (state_next == S_DONE);
  end

  // Status outputs, registered from the next-state view
  always_ff @(posedge clk) begin
    if (!nrst) begin
      label_ready_q  <= 1'b0;
      scoring_active <= 1'b0;
      scoring_done   <= 1'b0;
    end else begin
      label_ready_q  <= ready_next;
      scoring_active <= active_next;
      scoring_done   <= done_next;
    end
  end

  // FIFO pointers and occupancy; a finish flushes whatever is left
  always_ff @(posedge clk) begin
    if (!nrst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (en) begin
      if (clear | finish) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
      fifo_count <= fifo_count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= sb_if.label_class;
  end

  // Tallies and sticky error flags
  always_ff @(posedge clk) begin
    if (!nrst) begin
      total_count   <= '0;
      correct_count <= '0;
      err_flags     <= '0;
      for (int unsigned c = 0; c < NUM_CLASSES; c++) begin
        cls_total[c]   <= '0;
        cls_correct[c] <= '0;
      end
    end else if (en) begin
      if (clear) begin
        total_count   <= '0;
        correct_count <= '0;
        err_flags     <= '0;
        for (int unsigned c = 0; c < NUM_CLASSES; c++) begin
          cls_total[c]   <= '0;
          cls_correct[c] <= '0;
        end
      end else begin
        if (infer) total_count   <= sat_inc(total_count);
        if (hit)   correct_count <= sat_inc(correct_count);
        for (int unsigned c = 0; c < NUM_CLASSES; c++) begin
          if (pop_ok && (head == CLS_W'(c))) begin
            cls_total[c] <= sat_inc(cls_total[c]);
            if (hit) cls_correct[c] <= sat_inc(cls_correct[c]);
          end
        end
        err_flags <= err_flags | {extra, range_err, miss};
      end
    end
  end

  // Per-class read mux; out-of-range selects read as zero
  always_comb begin
    rd_total_c   = '0;
    rd_correct_c = '0;
    for (int unsigned c = 0; c < NUM_CLASSES; c++) begin
      if (class_rd_sel == CLS_W'(c)) begin
        rd_total_c   = cls_total[c];
        rd_correct_c = cls_correct[c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      class_rd_total   <= '0;
      class_rd_correct <= '0;
    end else if (en) begin
      class_rd_total   <= rd_total_c;
      class_rd_correct <= rd_correct_c;
    end
  end

endmodule

// File: tb/tb_oneshot_scoreboard.sv
// Self-checking bench for oneshot_scoreboard: a label-queue model predicts tallies,
// expected (total, correct) pairs are queued per inference and compared on output.
module tb_oneshot_scoreboard;

  logic        clk = 1'b0;
  logic        nrst;
  logic        en;
  logic        start_scoring;
  logic        testing_dataset_finished;
  logic [4:0]  class_rd_sel;
  logic [15:0] class_rd_total, class_rd_correct, total_count, correct_count;
  logic [2:0]  err_flags;
  logic        scoring_active, scoring_done;

  oneshot_scoreboard_if sb_if ();

  oneshot_scoreboard dut (
    .clk                      (clk),
    .nrst                     (nrst),
    .en                       (en),
    .start_scoring            (start_scoring),
    .sb_if                    (sb_if),
    .testing_dataset_finished (testing_dataset_finished),
    .class_rd_sel             (class_rd_sel),
    .class_rd_total           (class_rd_total),
    .class_rd_correct         (class_rd_correct),
    .total_count              (total_count),
    .correct_count            (correct_count),
    .err_flags                (err_flags),
    .scoring_active           (scoring_active),
    .scoring_done             (scoring_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] total;
    logic [15:0] correct;
  } tally_t;

  int checks = 0;
  int passed = 0;

  // Reference model state
  logic [4:0]  lbl_q [$];
  tally_t      exp_q [$];
  logic [15:0] m_total, m_correct;
  logic [15:0] m_cls_total   [32];
  logic [15:0] m_cls_correct [32];
  logic [2:0]  m_err;
  logic        m_active, m_done, m_ready;

  function automatic logic [15:0] sat16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic model_clear();
    lbl_q.delete();
    exp_q.delete();
    m_total   = '0;
    m_correct = '0;
    m_err     = '0;
    for (int i = 0; i < 32; i++) begin
      m_cls_total[i]   = '0;
      m_cls_correct[i] = '0;
    end
  endtask

  task automatic idle_inputs();
    start_scoring            = 1'b0;
    testing_dataset_finished = 1'b0;
    sb_if.label_valid        = 1'b0;
    sb_if.label_class        = '0;
    sb_if.checking_inference = 1'b0;
    sb_if.class_inference    = '0;
  endtask

  // Start pulse, optionally with a same-cycle label that must be ignored
  task automatic do_start(input logic push, input logic [4:0] pcls);
    start_scoring     = 1'b1;
    sb_if.label_valid = push;
    sb_if.label_class = pcls;
    @(posedge clk); #1;
    idle_inputs();
    model_clear();
    m_active = 1'b1;
    m_done   = 1'b0;
  endtask

  // One cycle of label/inference/finish stimulus, with the model advanced alongside
  task automatic step(input logic push, input logic [4:0] pcls,
                      input logic inf, input logic [4:0] icls, input logic fin);
    logic [4:0] h;
    tally_t     t;
    m_ready = m_active && (lbl_q.size() < 4);
    sb_if.label_valid        = push;
    sb_if.label_class        = pcls;
    sb_if.checking_inference = inf;
    sb_if.class_inference    = icls;
    testing_dataset_finished = fin;
    if (m_active) begin
      if (inf) begin
        m_total = sat16(m_total);
        if (lbl_q.size() == 0) begin
          m_err[0] = 1'b1;
        end else begin
          h = lbl_q.pop_front();
          m_cls_total[h] = sat16(m_cls_total[h]);
          if (h == icls) begin
            m_correct        = sat16(m_correct);
            m_cls_correct[h] = sat16(m_cls_correct[h]);
          end
        end
        t.total   = m_total;
        t.correct = m_correct;
        exp_q.push_back(t);
      end
      if (push && m_ready) begin
        if (pcls >= 5'd26) m_err[1] = 1'b1;
        else               lbl_q.push_back(pcls);
      end
      if (fin) begin
        if (lbl_q.size() != 0) m_err[2] = 1'b1;
        lbl_q.delete();
        m_active = 1'b0;
        m_done   = 1'b1;
      end
    end
    @(posedge clk); #1;
    idle_inputs();
    m_ready = m_active && (lbl_q.size() < 4);
  endtask

  task automatic test_reset();
    tally_t t;
    nrst = 1'b0;
    en   = 1'b1;
    class_rd_sel = 5'd0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    model_clear();
    m_active = 1'b0;
    m_done   = 1'b0;
    checks++;
    if ({total_count, correct_count} !== 32'h0)
      $display("FAIL reset_counts: got %h expected 00000000", {total_count, correct_count});
    else passed++;
    checks++;
    if ({err_flags, sb_if.label_ready, scoring_active, scoring_done} !== 6'b0)
      $display("FAIL reset_status: got %b expected 000000",
               {err_flags, sb_if.label_ready, scoring_active, scoring_done});
    else passed++;
    checks++;
    if ({class_rd_total, class_rd_correct} !== 32'h0)
      $display("FAIL reset_read: got %h expected 00000000", {class_rd_total, class_rd_correct});
    else passed++;
    nrst = 1'b1;
    @(posedge clk); #1;
    t = '0;
    exp_q.delete();
    checks++;
    if ({total_count, correct_count} !== {t.total, t.correct} || scoring_active !== 1'b0)
      $display("FAIL idle_after_reset: got %h/%b expected 00000000/0",
               {total_count, correct_count}, scoring_active);
    else passed++;
  endtask

  task automatic test_basic_run();
    logic [4:0] infs [3];
    tally_t t;
    infs[0] = 5'd3; infs[1] = 5'd7; infs[2] = 5'd2;
    do_start(1'b1, 5'd3);
    checks++;
    if ({scoring_active, sb_if.label_ready, scoring_done} !== 3'b110)
      $display("FAIL start_status: got %b expected 110",
               {scoring_active, sb_if.label_ready, scoring_done});
    else passed++;
    step(1'b1, 5'd3, 1'b0, 5'd0, 1'b0);
    step(1'b1, 5'd7, 1'b0, 5'd0, 1'b0);
    step(1'b1, 5'd7, 1'b0, 5'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 5'd0, 1'b1, infs[i], 1'b0);
      t = exp_q.pop_front();
      checks++;
      if ({total_count, correct_count} !== {t.total, t.correct})
        $display("FAIL basic_tally[%0d]: got %h/%h expected %h/%h", i,
                 total_count, correct_count, t.total, t.correct);
      else passed++;
    end
    step(1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
    checks++;
    if ({err_flags, scoring_done, scoring_active} !== {m_err, m_done, m_active})
      $display("FAIL basic_finish: got %b expected %b",
               {err_flags, scoring_done, scoring_active}, {m_err, m_done, m_active});
    else passed++;
    // Inference and label while DONE must be ignored
    step(1'b1, 5'd1, 1'b1, 5'd1, 1'b0);
    checks++;
    if ({total_count, correct_count} !== {m_total, m_correct} || m_total !== 16'd3)
      $display("FAIL done_ignores: got %h/%h expected %h/%h",
               total_count, correct_count, m_total, m_correct);
    else passed++;
    for (int s = 0; s < 4; s++) begin
      logic [4:0] sel;
      sel = (s == 0) ? 5'd7 : (s == 1) ? 5'd3 : (s == 2) ? 5'd2 : 5'd30;
      class_rd_sel = sel;
      @(posedge clk); #1;
      checks++;
      if ({class_rd_total, class_rd_correct} !==
          ((sel < 5'd26) ? {m_cls_total[sel], m_cls_correct[sel]} : 32'h0))
        $display("FAIL class_read[%0d]: got %h/%h expected %h/%h", sel,
                 class_rd_total, class_rd_correct,
                 (sel < 5'd26) ? m_cls_total[sel] : 16'h0,
                 (sel < 5'd26) ? m_cls_correct[sel] : 16'h0);
      else passed++;
    end
  endtask

  task automatic test_fifo_full();
    tally_t t;
    do_start(1'b0, 5'd0);
    for (int i = 0; i < 4; i++) step(1'b1, 5'(i), 1'b0, 5'd0, 1'b0);
    checks++;
    if (sb_if.label_ready !== m_ready || m_ready !== 1'b0)
      $display("FAIL full_ready: got %b expected 0", sb_if.label_ready);
    else passed++;
    step(1'b1, 5'd9, 1'b1, 5'd0, 1'b0);
    t = exp_q.pop_front();
    checks++;
    if ({total_count, correct_count, sb_if.label_ready} !== {t.total, t.correct, 1'b1})
      $display("FAIL full_pop: got %h/%h/%b expected %h/%h/1",
               total_count, correct_count, sb_if.label_ready, t.total, t.correct);
    else passed++;
    // Drain the three survivors, then one more: the dropped label must not appear
    for (int i = 1; i <= 4; i++) begin
      step(1'b0, 5'd0, 1'b1, (i == 4) ? 5'd9 : 5'(i), 1'b0);
      t = exp_q.pop_front();
      checks++;
      if ({total_count, correct_count, err_flags} !== {t.total, t.correct, m_err})
        $display("FAIL full_drain[%0d]: got %h/%h/%b expected %h/%h/%b", i,
                 total_count, correct_count, err_flags, t.total, t.correct, m_err);
      else passed++;
    end
  endtask

  task automatic test_empty_inference();
    tally_t t;
    do_start(1'b0, 5'd0);
    step(1'b1, 5'd5, 1'b1, 5'd5, 1'b0);
    t = exp_q.pop_front();
    checks++;
    if ({total_count, correct_count, err_flags} !== {t.total, t.correct, 3'b001})
      $display("FAIL empty_miss: got %h/%h/%b expected %h/%h/001",
               total_count, correct_count, err_flags, t.total, t.correct);
    else passed++;
    step(1'b0, 5'd0, 1'b1, 5'd5, 1'b0);
    t = exp_q.pop_front();
    checks++;
    if ({total_count, correct_count} !== {t.total, t.correct} || t.correct !== 16'd1)
      $display("FAIL empty_then_hit: got %h/%h expected %h/%h",
               total_count, correct_count, t.total, t.correct);
    else passed++;
  endtask

  task automatic test_range_and_extra();
    do_start(1'b0, 5'd0);
    step(1'b1, 5'd30, 1'b0, 5'd0, 1'b0);
    checks++;
    if (err_flags !== m_err || m_err !== 3'b010)
      $display("FAIL range_flag: got %b expected 010", err_flags);
    else passed++;
    step(1'b1, 5'd1, 1'b0, 5'd0, 1'b0);
    step(1'b1, 5'd2, 1'b0, 5'd0, 1'b0);
    // Finish with one pop: head must be label 1, not the dropped 30
    step(1'b0, 5'd0, 1'b1, 5'd1, 1'b1);
    checks++;
    if ({err_flags, scoring_done, correct_count} !== {m_err, 1'b1, m_correct} || m_err !== 3'b110)
      $display("FAIL extra_flag: got %b/%b/%h expected %b/1/%h",
               err_flags, scoring_done, correct_count, m_err, m_correct);
    else passed++;
    exp_q.delete();
  endtask

  task automatic test_enable();
    tally_t t;
    do_start(1'b0, 5'd0);
    step(1'b1, 5'd4, 1'b0, 5'd0, 1'b0);
    en = 1'b0;
    sb_if.checking_inference = 1'b1;
    sb_if.class_inference    = 5'd4;
    start_scoring            = 1'b1;
    @(posedge clk); #1;
    idle_inputs();
    en = 1'b1;
    checks++;
    if ({total_count, correct_count, scoring_active} !== {16'd0, 16'd0, 1'b1})
      $display("FAIL enable_hold: got %h/%h/%b expected 0000/0000/1",
               total_count, correct_count, scoring_active);
    else passed++;
    step(1'b0, 5'd0, 1'b1, 5'd4, 1'b0);
    t = exp_q.pop_front();
    checks++;
    if ({total_count, correct_count} !== {t.total, t.correct})
      $display("FAIL enable_resume: got %h/%h expected %h/%h",
               total_count, correct_count, t.total, t.correct);
    else passed++;
  endtask

  task automatic test_saturation();
    do_start(1'b0, 5'd0);
    step(1'b1, 5'd1, 1'b0, 5'd0, 1'b0);
    for (int i = 0; i < 65536; i++) begin
      step(1'b1, 5'd1, 1'b1, 5'd1, 1'b0);
      exp_q.delete();
    end
    checks++;
    if ({total_count, correct_count} !== {m_total, m_correct} || m_total !== 16'hFFFF)
      $display("FAIL saturate_global: got %h/%h expected %h/%h",
               total_count, correct_count, m_total, m_correct);
    else passed++;
    class_rd_sel = 5'd1;
    @(posedge clk); #1;
    checks++;
    if ({class_rd_total, class_rd_correct} !== {m_cls_total[1], m_cls_correct[1]})
      $display("FAIL saturate_class: got %h/%h expected %h/%h",
               class_rd_total, class_rd_correct, m_cls_total[1], m_cls_correct[1]);
    else passed++;
  endtask

  task automatic test_reset_midrun();
    do_start(1'b0, 5'd0);
    step(1'b1, 5'd2, 1'b0, 5'd0, 1'b0);
    step(1'b1, 5'd2, 1'b1, 5'd2, 1'b0);
    exp_q.delete();
    class_rd_sel = 5'd2;
    nrst = 1'b0;
    start_scoring = 1'b1;
    @(posedge clk); #1;
    start_scoring = 1'b0;
    checks++;
    if ({total_count, correct_count, class_rd_total, class_rd_correct} !== 64'h0)
      $display("FAIL midrun_counts: got %h expected 0",
               {total_count, correct_count, class_rd_total, class_rd_correct});
    else passed++;
    checks++;
    if ({err_flags, sb_if.label_ready, scoring_active, scoring_done} !== 6'b0)
      $display("FAIL midrun_status: got %b expected 000000",
               {err_flags, sb_if.label_ready, scoring_active, scoring_done});
    else passed++;
    nrst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic_run();
    test_fifo_full();
    test_empty_inference();
    test_range_and_extra();
    test_enable();
    test_saturation();
    test_reset_midrun();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/oneshot_scoreboard.md
ONESHOT_SCOREBOARD -- requirements
Module: oneshot_scoreboard

Interface
REQ-001 SHALL have parameter NUM_CLASSES, default 26, number of valid class labels (0..NUM_CLASSES-1).
REQ-002 SHALL have parameter CNT_W, default 16, width of every tally counter.
REQ-003 SHALL have parameter LBL_DEPTH, default 4, label FIFO depth (power of two).
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port nrst  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port en  input  1  global enable; low = all state holds, all inputs ignored.
REQ-007 SHALL have port start_scoring  input  1  one-cycle pulse; clears tallies, begins a test run.
REQ-008 SHALL have port label_valid  input  1  true-label push request.
REQ-009 SHALL have port label_class  input  5  true label of the next test sample.
REQ-010 SHALL have port label_ready  output  1  FIFO can accept a label this cycle.
REQ-011 SHALL have port checking_inference  input  1  one-cycle pulse; class_inference valid.
REQ-012 SHALL have port class_inference  input  5  predicted class from the associative memory.
REQ-013 SHALL have port testing_dataset_finished  input  1  level/pulse; last test sample delivered.
REQ-014 SHALL have port class_rd_sel  input  5  per-class tally read select.
REQ-015 SHALL have port class_rd_total / class_rd_correct  output  CNT_W each  per-class tallies for class_rd_sel.
REQ-016 SHALL have port total_count / correct_count  output  CNT_W each  global inference / hit tallies.
REQ-017 SHALL have port err_flags  output  3  sticky: [0] label_missing, [1] label_range, [2] label_extra.
REQ-018 SHALL have port scoring_active / scoring_done  output  1 each  state indicators.

Function
REQ-019 SHALL implement FSM IDLE -> ACTIVE (start_scoring) -> DONE (testing_dataset_finished); start_scoring in any state -> ACTIVE.
REQ-020 SHALL, on start_scoring, clear all tallies, err_flags and FIFO; same-cycle label push and inference are ignored.
REQ-021 SHALL drive label_ready = 1 only in ACTIVE with FIFO count < LBL_DEPTH (registered count; a same-cycle pop does not free a slot).
REQ-022 SHALL accept a label when label_valid & label_ready; label_class >= NUM_CLASSES is dropped and sets err_flags[1].
REQ-023 SHALL, on checking_inference in ACTIVE, pop FIFO head, increment total_count, class total[head], and on head == class_inference also correct_count and class correct[head].
REQ-024 SHALL, on checking_inference with FIFO empty (no same-cycle bypass), increment total_count only, set err_flags[0]; a same-cycle push is still stored.
REQ-025 SHALL saturate every counter at 2^CNT_W-1.
REQ-026 SHALL process a checking_inference coincident with testing_dataset_finished before entering DONE.
REQ-027 SHALL, on ACTIVE -> DONE, set err_flags[2] if FIFO still non-empty after that cycle's pop, and flush FIFO.
REQ-028 SHALL ignore checking_inference and label_valid in IDLE and DONE.
REQ-029 SHALL register class_rd_total/class_rd_correct with 1-cycle latency from class_rd_sel; sel >= NUM_CLASSES returns 0.
REQ-030 SHALL update total_count/correct_count on the cycle after the accepting edge (registered outputs).
REQ-031 SHALL hold scoring_done = 1 throughout DONE; scoring_active = 1 throughout ACTIVE.

Reset
REQ-032 SHALL, with nrst low at a clock edge, enter IDLE, empty FIFO, zero all counters, err_flags = 0, label_ready = 0, scoring_active = 0, scoring_done = 0, read outputs = 0.
REQ-033 SHALL let nrst override en and start_scoring; reset mid-run discards all tallies.

Verification
REQ-034 SHALL pass: start; push labels 3,7,7; inferences 3,7,2; finish -> total=3, correct=2, class 7 total=2 correct=1, err_flags=0, done=1.
REQ-035 SHALL pass: push 4 labels (FIFO full), 5th valid with concurrent inference -> label_ready=0, 5th not stored, FIFO count 3 next cycle.
REQ-036 SHALL pass: inference on empty FIFO with same-cycle push of 5 -> total=1, correct=0, err_flags=3'b001, next inference 5 -> correct=1.
REQ-037 SHALL pass: push label 30 -> not stored, err_flags[1]=1; finish with 2 labels pending -> err_flags[2]=1, FIFO empty.
REQ-038 SHALL pass: 65536 matching inferences -> total_count=correct_count=16'hFFFF, no wrap.
REQ-039 SHALL pass: en=0 during inference pulse -> no count change; nrst low mid-run -> all outputs reset values next cycle.
